muxd_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 3-input, 16-bit datapath mux (muxd) between three requesters.

---
 rtl/mycpu_pkg.sv | 15 +
 rtl/muxd.sv | 23 ++
 rtl/muxd_arbiter.sv | 121 ++++++++++++
 tb/tb_muxd_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared datapath types and constants for the CPU datapath blocks,
// including the muxd arbiter state encoding.
package mycpu_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int N_MUXD_IN  = 3;
  localparam int MUXD_SEL_W = 2;

  // Round-robin successor over the three muxd inputs (2 -> 0).
  function automatic logic [MUXD_SEL_W-1:0] rr_inc(input logic [MUXD_SEL_W-1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/muxd.sv
// Shared 3-input datapath mux; select 2'b11 is never driven by the arbiter
// and yields zero.
module muxd
  import mycpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [MUXD_SEL_W-1:0]          sel_in,
  input  logic [N_MUXD_IN-1:0][DW-1:0]   d_in,
  output logic [DW-1:0]                  m_out
);

  always_comb begin
    m_out = '0;
    case (sel_in)
      2'd0:    m_out = d_in[0];
      2'd1:    m_out = d_in[1];
      2'd2:    m_out = d_in[2];
      default: m_out = '0;
    endcase
  end

endmodule

// File: rtl/muxd_arbiter.sv
// Round-robin burst arbiter sharing muxd between three requesters; a grant is
// held until last beat, request drop, or MAX_HOLD accepted beats.
module muxd_arbiter
  import mycpu_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MUXD_IN-1:0]          req_in,
  input  logic [N_MUXD_IN-1:0]          last_in,
  input  logic [N_MUXD_IN-1:0][DW-1:0]  d_in,
  input  logic                          m_ready_in,
  output logic                          m_valid_out,
  output logic [DW-1:0]                 m_out,
  output logic [N_MUXD_IN-1:0]          gnt_out,
  output logic [MUXD_SEL_W-1:0]         sel_out,
  output logic                          busy_out
);

  localparam int HCW = $clog2(MAX_HOLD + 1);

  arb_state_t              state_q, state_d;
  logic [N_MUXD_IN-1:0]    gnt_q, gnt_d;
  logic [MUXD_SEL_W-1:0]   sel_q, sel_d;
  logic [MUXD_SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;

  logic                    busy, req_own, last_own, accepted, hold_last, release_own;
  logic [MUXD_SEL_W-1:0]   pick_ptr, cand, win_idx;
  logic                    win_vld;

  // gnt_q is one-hot or zero, so masking picks out the owner's bits.
  assign busy        = (state_q == ARB_GRANT);
  assign req_own     = |(req_in & gnt_q);
  assign last_own    = |(last_in & gnt_q);
  assign m_valid_out = busy & req_own;
  assign accepted    = m_valid_out & m_ready_in;
  assign hold_last   = (hold_cnt_q == HCW'(MAX_HOLD - 1));
  assign release_own = busy & (~req_own | (accepted & (last_own | hold_last)));

  // Pick uses the post-release pointer so the next owner starts on the same edge.
  always_comb begin
    pick_ptr = release_own ? rr_inc(sel_q) : rr_ptr_q;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = pick_ptr;
    for (int k = 0; k < N_MUXD_IN; k++) begin
      if (!win_vld && req_in[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = rr_inc(cand);
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_vld) begin
          state_d    = ARB_GRANT;
          gnt_d      = 3'b001 << win_idx;
          sel_d      = win_idx;
          hold_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (release_own) begin
          rr_ptr_d   = rr_inc(sel_q);
          hold_cnt_d = '0;
          if (win_vld) begin
            gnt_d = 3'b001 << win_idx;
            sel_d = win_idx;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end else if (accepted) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_out  = gnt_q;
  assign sel_out  = sel_q;
  assign busy_out = busy;

  muxd #(.DW(DW)) u_muxd (
    .sel_in (sel_q),
    .d_in   (d_in),
    .m_out  (m_out)
  );

endmodule

// File: tb/tb_muxd_arbiter.sv
// Scoreboard bench for muxd_arbiter: stimulus queues expected accepted beats,
// a negedge monitor pops and compares each beat the DUT hands downstream.
module tb_muxd_arbiter;

  localparam int DW = 16;

  typedef struct packed {
    logic [2:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           req_in, last_in;
  logic [2:0][DW-1:0]   d_in;
  logic                 m_ready_in;
  logic                 m_valid_out, busy_out;
  logic [DW-1:0]        m_out;
  logic [2:0]           gnt_out;
  logic [1:0]           sel_out;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  localparam logic [DW-1:0] D0 = 16'hA5A5;
  localparam logic [DW-1:0] D1 = 16'h1234;
  localparam logic [DW-1:0] D2 = 16'hBEEF;

  always #5 clk = ~clk;

  muxd_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .last_in     (last_in),
    .d_in        (d_in),
    .m_ready_in  (m_ready_in),
    .m_valid_out (m_valid_out),
    .m_out       (m_out),
    .gnt_out     (gnt_out),
    .sel_out     (sel_out),
    .busy_out    (busy_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk(input int o);
    beat_t b;
    b.gnt  = 3'b001 << o;
    b.sel  = 2'(o);
    b.data = (o == 0) ? D0 : (o == 1) ? D1 : D2;
    return b;
  endfunction

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid_out && m_ready_in) begin
      beat_t got;
      got = '{gnt: gnt_out, sel: sel_out, data: m_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got gnt=%b sel=%0d data=%h, none queued", got.gnt, got.sel, got.data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL beat: got gnt=%b sel=%0d data=%h expected gnt=%b sel=%0d data=%h",
                   got.gnt, got.sel, got.data, e.gnt, e.sel, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_in = '0;
    last_in = '0;
    m_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    d_in[0] = D0; d_in[1] = D1; d_in[2] = D2;
    rst = 1'b1; req_in = '0; last_in = '0; m_ready_in = 1'b1;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_out), 32'h0);
    chk("rst_sel", 32'(sel_out), 32'h0);
    chk("rst_valid", 32'(m_valid_out), 32'h0);
    chk("rst_busy", 32'(busy_out), 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 2: single requester, 1-clk grant latency
    req_in = 3'b001;
    exp_q.push_back(mk(0));
    @(negedge clk);
    chk("t2_latency_gnt", 32'(gnt_out), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t2_gnt", 32'(gnt_out), 32'h1);
    chk("t2_sel", 32'(sel_out), 32'h0);
    chk("t2_valid", 32'(m_valid_out), 32'h1);
    chk("t2_data", 32'(m_out), 32'(D0));
    @(posedge clk); #1 req_in = '0;
    @(posedge clk);

    // 3: all requesting, hold limit rotates 0,1,2,0 with no bubbles
    do_reset();
    req_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(mk(r % 3));
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("t3_no_bubble", 32'(m_valid_out), 32'h1);
      @(posedge clk);
    end
    #1 req_in = '0;
    @(negedge clk);
    chk("t3_next_owner", 32'(gnt_out), 32'h2);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk);

    // 4: backpressure holds owner 1, then exactly MAX_HOLD beats before rotating
    do_reset();
    req_in = 3'b110;
    m_ready_in = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_bp_gnt", 32'(gnt_out), 32'h2);
      chk("t4_bp_sel", 32'(sel_out), 32'h1);
      chk("t4_bp_data", 32'(m_out), 32'(D1));
      @(posedge clk);
    end
    #1 m_ready_in = 1'b1;
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(1));
    repeat (4) @(posedge clk);
    #1 req_in = '0;
    @(negedge clk);
    chk("t4_rotate_gnt", 32'(gnt_out), 32'h4);
    chk("t4_sb_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk);

    // 5: last beat from owner 0 hands over to pending requester 2 on the same edge
    do_reset();
    req_in = 3'b101;
    last_in = 3'b001;
    exp_q.push_back(mk(0));
    exp_q.push_back(mk(2));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t5_gnt", 32'(gnt_out), 32'h4);
    chk("t5_sel", 32'(sel_out), 32'h2);
    chk("t5_valid", 32'(m_valid_out), 32'h1);
    @(posedge clk); #1 req_in = '0; last_in = '0;
    @(posedge clk);

    // 6: reset mid-burst, then pointer restarts at 0
    do_reset();
    req_in = 3'b100;
    exp_q.push_back(mk(2));
    exp_q.push_back(mk(2));
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; req_in = 3'b110;
    @(negedge clk);
    chk("t6_rst_gnt", 32'(gnt_out), 32'h0);
    chk("t6_rst_sel", 32'(sel_out), 32'h0);
    chk("t6_rst_valid", 32'(m_valid_out), 32'h0);
    chk("t6_rst_busy", 32'(busy_out), 32'h0);
    exp_q.push_back(mk(1));
    @(posedge clk);
    @(negedge clk);
    chk("t6_regrant", 32'(gnt_out), 32'h2);
    @(posedge clk); #1 req_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
